// File: rtl/mem_access_if.sv
// mem_access_if: request/response and word-memory signals of the load/store unit.
// Ports: req_* (pipeline request), resp_* (completion), mem_* (word-addressed memory).
// Modport slave is the unit's view; master is the pipeline+memory view.
interface mem_access_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_wr;
    logic [31:0] mem_address;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    modport slave (
        input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err, mem_wr, mem_address, mem_wdata
    );
    modport master (
        output req_valid, req_write, req_size, req_signed, req_addr, req_wdata, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err, mem_wr, mem_address, mem_wdata
    );
endinterface

// File: rtl/mem_access_unit.sv
// mem_access_unit: byte/half/word load-store initiator on a word-addressed memory.
// Ports: clk, rst (sync, active-high), bus (mem_access_if.slave: request, response, memory).
module mem_access_unit #(
    parameter int ADDR_WORDS = 100
) (
    input logic        clk,
    input logic        rst,
    mem_access_if.slave bus
);
    typedef enum logic [2:0] {IDLE, READ, CAPTURE, WRITE, RESP} state_t;
    localparam logic [29:0] LIMIT = 30'(ADDR_WORDS);
    state_t      state;
    logic        wr;
    logic [1:0]  size;
    logic        sgn;
    logic [1:0]  lane;
    logic [31:0] wdata;
    logic        err;
    logic [4:0]  sh;
    logic [31:0] shifted;
    logic [31:0] mask;
    logic [31:0] merged;
    logic [31:0] loaded;
    always_comb begin
        err = (bus.req_size == 2'b11) ||
              (bus.req_size == 2'b01 && bus.req_addr[0]) ||
              (bus.req_size == 2'b10 && bus.req_addr[1:0] != 2'b00) ||
              (bus.req_addr[31:2] >= LIMIT);
        // halves are aligned, so the byte-lane shift also selects the half lane
        sh      = {lane, 3'b000};
        shifted = bus.mem_rdata >> sh;
        mask    = (size == 2'b00 ? 32'h0000_00FF : 32'h0000_FFFF) << sh;
        merged  = (bus.mem_rdata & ~mask) | ((wdata << sh) & mask);
        loaded  = size == 2'b10 ? bus.mem_rdata :
                  size == 2'b01 ? {{16{sgn & shifted[15]}}, shifted[15:0]} :
                                  {{24{sgn & shifted[7]}}, shifted[7:0]};
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            bus.req_ready   <= 1'b1;
            bus.resp_valid  <= 1'b0;
            bus.resp_err    <= 1'b0;
            bus.resp_rdata  <= '0;
            bus.mem_wr      <= 1'b0;
            bus.mem_address <= '0;
            bus.mem_wdata   <= '0;
            wr              <= 1'b0;
            size            <= '0;
            sgn             <= 1'b0;
            lane            <= '0;
            wdata           <= '0;
        end else begin
            case (state)
                IDLE: if (bus.req_valid) begin
                    wr            <= bus.req_write;
                    size          <= bus.req_size;
                    sgn           <= bus.req_signed;
                    lane          <= bus.req_addr[1:0];
                    wdata         <= bus.req_wdata;
                    bus.req_ready <= 1'b0;
                    bus.resp_err  <= err;
                    bus.resp_rdata <= '0;
                    if (!err) bus.mem_address <= {2'b00, bus.req_addr[31:2]};
                    if (err) begin
                        bus.resp_valid <= 1'b1;
                        state          <= RESP;
                    end else if (bus.req_write && bus.req_size == 2'b10) begin
                        bus.mem_wr    <= 1'b1;
                        bus.mem_wdata <= bus.req_wdata;
                        state         <= WRITE;
                    end else begin
                        state <= READ;
                    end
                end
                READ: state <= CAPTURE;
                CAPTURE: if (wr) begin
                    bus.mem_wdata <= merged;
                    bus.mem_wr    <= 1'b1;
                    state         <= WRITE;
                end else begin
                    bus.resp_rdata <= loaded;
                    bus.resp_valid <= 1'b1;
                    state          <= RESP;
                end
                WRITE: begin
                    bus.mem_wr     <= 1'b0;
                    bus.resp_valid <= 1'b1;
                    state          <= RESP;
                end
                RESP: begin
                    bus.resp_valid <= 1'b0;
                    bus.req_ready  <= 1'b1;
                    state          <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: table-driven directed checks of mem_access_unit with a behavioural memory.
module tb_mem_access_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    mem_access_if bus ();
    mem_access_unit #(.ADDR_WORDS(100)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;

    logic [31:0] mem [0:127];
    logic        pre_en = 1'b0;
    logic [6:0]  pre_idx = '0;
    logic [31:0] pre_data = '0;
    int          wr_cnt = 0;
    logic [31:0] last_waddr = '0;
    int          errors = 0;
    int          checks = 0;

    always @(posedge clk) bus.mem_rdata <= (bus.mem_address < 32'd100) ? mem[bus.mem_address[6:0]] : 32'h0;
    always @(negedge clk) begin
        if (bus.mem_wr) begin
            mem[bus.mem_address[6:0]] <= bus.mem_wdata;
            wr_cnt = wr_cnt + 1;
            last_waddr = bus.mem_address;
        end else if (pre_en) begin
            mem[pre_idx] <= pre_data;
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got hang expected completion");
        $fatal(1);
    end

    typedef struct {
        logic        wr;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [6:0]  idx;
        logic [31:0] init;
        logic        err;
        logic [31:0] rdata;
        int          lat;
        logic [31:0] word;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic preload(input logic [6:0] idx, input logic [31:0] data);
        pre_idx = idx;
        pre_data = data;
        pre_en = 1'b1;
        @(negedge clk);
        #1 pre_en = 1'b0;
    endtask

    task automatic run_vec(input vec_t t, input int n);
        int lat;
        int w0;
        preload(t.idx, t.init);
        w0 = wr_cnt;
        @(negedge clk);
        chk($sformatf("v%0d ready", n), 32'(bus.req_ready), 32'd1);
        bus.req_write = t.wr;
        bus.req_size = t.size;
        bus.req_signed = t.sgn;
        bus.req_addr = t.addr;
        bus.req_wdata = t.wdata;
        bus.req_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.req_addr = 32'hFFFF_FFFC;
        bus.req_wdata = 32'h0;
        bus.req_size = 2'b10;
        lat = 1;
        while (!bus.resp_valid && lat < 8) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk($sformatf("v%0d latency", n), 32'(lat), 32'(t.lat));
        chk($sformatf("v%0d resp_err", n), 32'(bus.resp_err), 32'(t.err));
        chk($sformatf("v%0d resp_rdata", n), bus.resp_rdata, t.rdata);
        @(posedge clk);
        #1;
        chk($sformatf("v%0d resp_valid one cycle", n), 32'(bus.resp_valid), 32'd0);
        chk($sformatf("v%0d ready after", n), 32'(bus.req_ready), 32'd1);
        chk($sformatf("v%0d mem word", n), mem[t.idx], t.word);
        chk($sformatf("v%0d write count", n), 32'(wr_cnt - w0), 32'(t.wr && !t.err));
        if (t.wr && !t.err) chk($sformatf("v%0d write addr", n), last_waddr, 32'(t.idx));
    endtask

    vec_t v [16];
    logic [31:0] b2b_addr [3];
    logic [31:0] b2b_exp [3];
    int acc [3];

    initial begin
        int n, k, cyc, busy, w0, rv;
        v[0]  = '{1'b1, 2'b10, 1'b0, 32'h10,  32'hDEADBEEF, 7'd4,  32'h00000000, 1'b0, 32'h00000000, 2, 32'hDEADBEEF};
        v[1]  = '{1'b0, 2'b10, 1'b0, 32'h10,  32'h00000000, 7'd4,  32'hDEADBEEF, 1'b0, 32'hDEADBEEF, 3, 32'hDEADBEEF};
        v[2]  = '{1'b1, 2'b00, 1'b0, 32'h12,  32'h000000AB, 7'd4,  32'h11223344, 1'b0, 32'h00000000, 4, 32'h11AB3344};
        v[3]  = '{1'b0, 2'b00, 1'b1, 32'h13,  32'h00000000, 7'd4,  32'h80F07F01, 1'b0, 32'hFFFFFF80, 3, 32'h80F07F01};
        v[4]  = '{1'b0, 2'b00, 1'b0, 32'h13,  32'h00000000, 7'd4,  32'h80F07F01, 1'b0, 32'h00000080, 3, 32'h80F07F01};
        v[5]  = '{1'b0, 2'b01, 1'b1, 32'h12,  32'h00000000, 7'd4,  32'h80F07F01, 1'b0, 32'hFFFF80F0, 3, 32'h80F07F01};
        v[6]  = '{1'b0, 2'b01, 1'b1, 32'h10,  32'h00000000, 7'd4,  32'h80F07F01, 1'b0, 32'h00007F01, 3, 32'h80F07F01};
        v[7]  = '{1'b0, 2'b01, 1'b0, 32'h12,  32'h00000000, 7'd4,  32'h80F07F01, 1'b0, 32'h000080F0, 3, 32'h80F07F01};
        v[8]  = '{1'b1, 2'b01, 1'b0, 32'h12,  32'h1234CAFE, 7'd4,  32'h11223344, 1'b0, 32'h00000000, 4, 32'hCAFE3344};
        v[9]  = '{1'b1, 2'b00, 1'b1, 32'h10,  32'hFFFFFF5A, 7'd4,  32'h11223344, 1'b0, 32'h00000000, 4, 32'h1122335A};
        v[10] = '{1'b0, 2'b01, 1'b1, 32'h11,  32'h00000000, 7'd4,  32'h55555555, 1'b1, 32'h00000000, 1, 32'h55555555};
        v[11] = '{1'b1, 2'b10, 1'b0, 32'h12,  32'hDEADBEEF, 7'd4,  32'h55555555, 1'b1, 32'h00000000, 1, 32'h55555555};
        v[12] = '{1'b1, 2'b11, 1'b0, 32'h10,  32'hDEADBEEF, 7'd4,  32'h55555555, 1'b1, 32'h00000000, 1, 32'h55555555};
        v[13] = '{1'b1, 2'b10, 1'b0, 32'h190, 32'hDEADBEEF, 7'd99, 32'h12345678, 1'b1, 32'h00000000, 1, 32'h12345678};
        v[14] = '{1'b0, 2'b10, 1'b0, 32'h18C, 32'h00000000, 7'd99, 32'h99AABBCC, 1'b0, 32'h99AABBCC, 3, 32'h99AABBCC};
        v[15] = '{1'b0, 2'b10, 1'b1, 32'h190, 32'h00000000, 7'd99, 32'h99AABBCC, 1'b1, 32'h00000000, 1, 32'h99AABBCC};
        b2b_addr = '{32'h14, 32'h18, 32'h1C};
        b2b_exp  = '{32'h00000055, 32'h00000066, 32'h00000077};

        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_size = 2'b00;
        bus.req_signed = 1'b0;
        bus.req_addr = '0;
        bus.req_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset req_ready", 32'(bus.req_ready), 32'd1);
        chk("reset resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("reset resp_err", 32'(bus.resp_err), 32'd0);
        chk("reset resp_rdata", bus.resp_rdata, 32'd0);
        chk("reset mem_wr", 32'(bus.mem_wr), 32'd0);
        chk("reset mem_address", bus.mem_address, 32'd0);
        chk("reset mem_wdata", bus.mem_wdata, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 16; i++) run_vec(v[i], i);

        preload(7'd5, 32'h00000055);
        preload(7'd6, 32'h00000066);
        preload(7'd7, 32'h00000077);
        preload(7'd8, 32'hBAD0BAD0);
        bus.req_write = 1'b0;
        bus.req_size = 2'b10;
        bus.req_signed = 1'b0;
        n = 0;
        k = 0;
        cyc = 0;
        busy = 0;
        while (k < 3 && cyc < 40) begin
            @(negedge clk);
            if (n < 3 && bus.req_ready) begin
                bus.req_valid = 1'b1;
                bus.req_addr = b2b_addr[n];
                acc[n] = cyc;
                n++;
            end else begin
                bus.req_addr = 32'h20;
                if (!bus.req_ready) busy++;
                if (n == 3) bus.req_valid = 1'b0;
            end
            @(posedge clk);
            #1;
            cyc++;
            if (bus.resp_valid) begin
                chk($sformatf("b2b rdata %0d", k), bus.resp_rdata, b2b_exp[k]);
                k++;
            end
        end
        bus.req_valid = 1'b0;
        chk("b2b responses", 32'(k), 32'd3);
        chk("b2b spacing 0-1", 32'(acc[1] - acc[0]), 32'd4);
        chk("b2b spacing 1-2", 32'(acc[2] - acc[1]), 32'd4);
        chk("b2b busy cycles", 32'(busy), 32'd8);
        @(posedge clk);
        #1;

        preload(7'd4, 32'h11223344);
        w0 = wr_cnt;
        @(negedge clk);
        bus.req_write = 1'b1;
        bus.req_size = 2'b00;
        bus.req_addr = 32'h12;
        bus.req_wdata = 32'hAB;
        bus.req_valid = 1'b1;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst mid req_ready", 32'(bus.req_ready), 32'd1);
        chk("rst mid mem_wr", 32'(bus.mem_wr), 32'd0);
        chk("rst mid resp_valid", 32'(bus.resp_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        rv = 0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (bus.resp_valid) rv++;
        end
        chk("rst mid no resp", 32'(rv), 32'd0);
        chk("rst mid no write", 32'(wr_cnt - w0), 32'd0);
        chk("rst mid mem word", mem[4], 32'h11223344);
        chk("rst mid idle ready", 32'(bus.req_ready), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
